johnson_phase_monitor: RTL
==========================

# johnson_phase_monitor

Downstream consumer of the 8-bit Johnson ring counter in the tt_um top level. Samples the counter's code each enabled cycle, decodes it to a 4-bit phase index, and checks that every new code is the legal one-step successor of the last. A lock FSM, wrap pulse, revolution counter and saturating error counter turn the raw ring state into a trusted phase source for later stages.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct steps needed to enter LOCKED, range 1..15.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- jc_in  in  8  Johnson code from the counter.
- jc_valid  in  1  sample enable; jc_in is ignored when low.
- clr_fault  in  1  leave FAULT and clear err_count.
- phase  out  4  decoded phase of the last legal sample.
- phase_valid  out  1  phase holds a legal decoded value.
- step_err  out  1  one-cycle pulse on an illegal code or an illegal step.
- wrap_pulse  out  1  one-cycle pulse on the phase 15→0 step while LOCKED.
- locked  out  1  FSM is in LOCKED.
- fault  out  1  FSM is in FAULT.
- err_count  out  ERR_W  saturating count of step_err pulses.
- rev_count  out  8  count of wrap_pulse events, modulo 256.

## Operation
- Legal codes, 16 total:
  - phase k = 0..8: code = (1<<k)-1, so 0x00, 0x01 … 0xFF.
  - phase k = 9..15: code = (0xFF<<(k-8)) & 0xFF, so 0xFE … 0x80.
  - All other 240 codes are illegal.
- Step classification for a legal sample against the stored previous phase p:
  - equal to p: hold; no error, acquire count unchanged.
  - equal to (p+1) mod 16: good step.
  - anything else: bad step.
- FSM states: UNLOCKED, ACQUIRE, LOCKED, FAULT.
  - UNLOCKED: a legal sample stores the phase and moves to ACQUIRE with count 0. An illegal sample pulses step_err.
  - ACQUIRE:
    - good step: count+1; reaching LOCK_COUNT moves to LOCKED.
    - bad step: step_err, the new phase becomes the reference, count=0.
    - illegal code: step_err, go to UNLOCKED, phase_valid=0.
  - LOCKED: a good step from 15 to 0 pulses wrap_pulse and increments rev_count. A bad step or illegal code pulses step_err and moves to FAULT.
  - FAULT: samples are still decoded and the phase is updated. Further errors pulse step_err and count. clr_fault moves to UNLOCKED.
- err_count saturates at 2^ERR_W-1. clr_fault clears it in any state.
- clr_fault in a non-FAULT state only clears err_count; the state is unchanged.

## Timing
- All outputs are registered. The effects of the sample taken at edge N are visible after edge N; latency is 1 cycle.
- jc_valid low: state, phase and counters hold; pulses are 0.
- clr_fault and a sample at the same edge:
  - in FAULT, clear wins, the sample is discarded, next state is UNLOCKED;
  - elsewhere, the sample is processed and err_count is cleared, with the clear winning over any increment.
- Reset (rst_n=0 at an edge), including mid-sequence:
  - state=UNLOCKED;
  - phase=0, phase_valid=0, step_err=0, wrap_pulse=0, locked=0, fault=0;
  - err_count=0, rev_count=0.

## Configuration
- JPM_REV_COUNT_EN defined: rev_count logic is present as described.
- JPM_REV_COUNT_EN undefined:
  - rev_count is tied to 0 and the register is removed;
  - wrap_pulse still operates.

## Structure
- Package johnson_pkg holds:
  - JC_W = 8 and PHASE_W = 4;
  - the FSM state enum;
  - a function giving the legal code for a phase, for the bench reference model.
- One sub-module, johnson_phase_lut: purely combinational mapping of jc_in to {legal, phase[3:0]}.
- The FSM, step comparison and counters stay in the top module.

## Test plan
- Reset, then feed 0x00,0x01,0x03,0x07,0x0F with jc_valid=1: phase 0..4, locked=1 after the 5th sample, no step_err.
- Locked, run through 0x80 then 0x00: wrap_pulse is a single cycle and rev_count increments by 1. With JPM_REV_COUNT_EN undefined, rev_count stays 0.
- Locked at 0x07, inject 0x05: step_err pulse, fault=1, err_count=1. Assert clr_fault alone: next cycle UNLOCKED, err_count=0.
- ACQUIRE at phase 2 (0x03), feed 0x1F: step_err, stays ACQUIRE, phase=5, count resets. Then hold 0x1F for 3 cycles: no error, not locked.
- Drive 300 illegal codes in UNLOCKED: err_count saturates at 255. Apply rst_n=0 mid-run: all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared widths, lock FSM states and legal Johnson code helper
package johnson_pkg;

   localparam int JC_W    = 8;
   localparam int PHASE_W = 4;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_FAULT    = 2'd3
   } jpm_state_e;

   // Phases 0..8 fill with ones from the LSB, 9..15 drain them from the LSB.
   function automatic logic [JC_W-1:0] jc_code(input logic [PHASE_W-1:0] k);
      logic [JC_W-1:0] ones;
      ones = '1;
      if (k <= 4'd8) return ones >> (4'd8 - k);
      else           return ones << (k - 4'd8);
   endfunction

endpackage

// File: rtl/johnson_phase_lut.sv
// rtl/johnson_phase_lut.sv - combinational Johnson code to {legal, phase} decoder
module johnson_phase_lut
   import johnson_pkg::*;
(
   input  logic [JC_W-1:0]    jc_i,
   output logic               legal_o,
   output logic [PHASE_W-1:0] phase_o
);

   always_comb begin
      legal_o = 1'b0;
      phase_o = '0;
      for (int k = 0; k < (1 << PHASE_W); k++) begin
         if (jc_i == jc_code(PHASE_W'(k))) begin
            legal_o = 1'b1;
            phase_o = PHASE_W'(k);
         end
      end
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// rtl/johnson_phase_monitor.sv - Johnson ring phase decoder, step checker and lock FSM
// Define JPM_REV_COUNT_EN to build the revolution counter; otherwise rev_count is 0.
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [JC_W-1:0]    jc_in,
   input  logic               jc_valid,
   input  logic               clr_fault,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_valid,
   output logic               step_err,
   output logic               wrap_pulse,
   output logic               locked,
   output logic               fault,
   output logic [ERR_W-1:0]   err_count,
   output logic [7:0]         rev_count
);

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   jpm_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d, phase_inc;
   logic               pv_q, pv_d;
   logic               step_err_q, step_err_d;
   logic               wrap_q, wrap_d;
   logic [3:0]         cnt_q, cnt_d, cnt_inc;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               lut_legal, is_hold, is_good;
   logic [PHASE_W-1:0] lut_phase;

   johnson_phase_lut u_lut (
      .jc_i    (jc_in),
      .legal_o (lut_legal),
      .phase_o (lut_phase)
   );

   assign phase_inc = phase_q + 4'd1;
   assign cnt_inc   = cnt_q + 4'd1;
   assign is_hold   = lut_legal && (lut_phase == phase_q);
   assign is_good   = lut_legal && (lut_phase == phase_inc);

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      pv_d       = pv_q;
      cnt_d      = cnt_q;
      step_err_d = 1'b0;
      wrap_d     = 1'b0;
      // A clear in FAULT discards any coincident sample.
      if (clr_fault && state_q == ST_FAULT) begin
         state_d = ST_UNLOCKED;
      end else if (jc_valid) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (lut_legal) begin
                  phase_d = lut_phase;
                  pv_d    = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_ACQUIRE;
               end else begin
                  step_err_d = 1'b1;
               end
            end
            ST_ACQUIRE: begin
               if (!lut_legal) begin
                  step_err_d = 1'b1;
                  pv_d       = 1'b0;
                  state_d    = ST_UNLOCKED;
               end else if (is_good) begin
                  phase_d = lut_phase;
                  cnt_d   = cnt_inc;
                  if (cnt_inc == LOCK_C) state_d = ST_LOCKED;
               end else if (!is_hold) begin
                  step_err_d = 1'b1;
                  phase_d    = lut_phase;
                  cnt_d      = '0;
               end
            end
            ST_LOCKED: begin
               if (is_good) begin
                  phase_d = lut_phase;
                  wrap_d  = (phase_q == 4'd15);
               end else if (!is_hold) begin
                  step_err_d = 1'b1;
                  if (lut_legal) phase_d = lut_phase;
                  state_d = ST_FAULT;
               end
            end
            default: begin
               if (lut_legal) phase_d = lut_phase;
               if (!is_good && !is_hold) step_err_d = 1'b1;
            end
         endcase
      end
      if (clr_fault)                           err_d = '0;
      else if (step_err_d && err_q != ERR_MAX) err_d = err_q + 1'b1;
      else                                     err_d = err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_UNLOCKED;
         phase_q    <= '0;
         pv_q       <= 1'b0;
         cnt_q      <= '0;
         step_err_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         pv_q       <= pv_d;
         cnt_q      <= cnt_d;
         step_err_q <= step_err_d;
         wrap_q     <= wrap_d;
         err_q      <= err_d;
      end
   end

`ifdef JPM_REV_COUNT_EN
   logic [7:0] rev_q;
   always_ff @(posedge clk) begin
      if (!rst_n)      rev_q <= '0;
      else if (wrap_d) rev_q <= rev_q + 8'd1;
   end
   assign rev_count = rev_q;
`else
   assign rev_count = '0;
`endif

   assign phase       = phase_q;
   assign phase_valid = pv_q;
   assign step_err    = step_err_q;
   assign wrap_pulse  = wrap_q;
   assign locked      = (state_q == ST_LOCKED);
   assign fault       = (state_q == ST_FAULT);
   assign err_count   = err_q;

endmodule
